// File: rtl/snn_seq_pkg.sv
// Shared types and constants for the SNN layer sequencer: FSM state encoding,
// the "no layer" id and the layer-count clamp helper.
package snn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    NEXT      = 3'd5,
    FINISH    = 3'd6
  } seq_state_e;

  localparam logic [7:0] LAYER_ID_NONE = 8'hFF;

  function automatic logic [7:0] clamp_layers(input logic [7:0] n, input int unsigned max_l);
    return (32'(n) > max_l) ? 8'(max_l) : n;
  endfunction

endpackage

// File: rtl/snn_layer_sequencer_if.sv
// Execute handshake between the layer sequencer (master) and the SNN layer manager (slave).
interface snn_layer_sequencer_if;
  import snn_seq_pkg::*;

  logic [7:0] execute_layer_id;
  logic       execute_start;
  logic       execute_done;

  modport master (output execute_layer_id, output execute_start, input execute_done);
  modport slave  (input execute_layer_id, input execute_start, output execute_done);

endinterface

// File: rtl/snn_seq_watchdog.sv
// Per-layer hang detector: counts cycles spent waiting on the layer manager and
// flags expiry once the count reaches a non-zero limit.
module snn_seq_watchdog
  import snn_seq_pkg::*;
#(
  parameter int WDOG_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [WDOG_WIDTH-1:0] limit_i,
  output logic                  expired_o
);

  logic [WDOG_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + WDOG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expired_o = enable_i && (limit_i != '0) && (cnt_q >= limit_i);

endmodule

// File: rtl/snn_layer_sequencer.sv
// Walks layers 0..num_layers-1 for each timestep through the layer manager's
// execute handshake. Optional hung-layer timeout: define SNN_SEQ_WATCHDOG_EN.
module snn_layer_sequencer
  import snn_seq_pkg::*;
#(
  parameter int MAX_LAYERS     = 16,
  parameter int TIMESTEP_WIDTH = 16,
  parameter int WDOG_WIDTH     = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                num_layers,
  input  logic [TIMESTEP_WIDTH-1:0] num_timesteps,
  input  logic [MAX_LAYERS-1:0]     skip_mask,
  input  logic [WDOG_WIDTH-1:0]     wdog_limit,
  snn_layer_sequencer_if.master     exec,
  output logic                      busy,
  output logic                      run_done,
  output logic                      run_aborted,
  output logic [7:0]                current_layer,
  output logic [TIMESTEP_WIDTH-1:0] current_timestep,
  output logic [31:0]               layers_executed,
  output logic                      error_timeout
);

  localparam int LIDX_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam logic [TIMESTEP_WIDTH-1:0] TS_ONE = TIMESTEP_WIDTH'(1);

  seq_state_e                state_q, state_d;
  logic [7:0]                nl_q, nl_d;
  logic [TIMESTEP_WIDTH-1:0] nts_q, nts_d;
  logic [MAX_LAYERS-1:0]     skip_q, skip_d;
  logic [7:0]                layer_q, layer_d;
  logic [TIMESTEP_WIDTH-1:0] ts_q, ts_d;
  logic [7:0]                exec_id_q, exec_id_d;
  logic                      exec_start_q, exec_start_d;
  logic [31:0]               exec_cnt_q, exec_cnt_d;
  logic                      busy_q, busy_d;
  logic                      run_done_q, run_done_d;
  logic                      run_aborted_q, run_aborted_d;
  logic                      err_q, err_d;
  logic                      wd_clear, wd_enable;
  logic [7:0]                nl_clamped;

  assign nl_clamped = clamp_layers(num_layers, MAX_LAYERS);

`ifdef SNN_SEQ_WATCHDOG_EN
  logic wd_expired;

  snn_seq_watchdog #(.WDOG_WIDTH(WDOG_WIDTH)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .limit_i   (wdog_limit),
    .expired_o (wd_expired)
  );

  assign error_timeout = err_q;
`else
  logic unused_wdog;
  assign unused_wdog   = ^{wdog_limit, wd_clear, wd_enable, err_q};
  assign error_timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    nl_d          = nl_q;
    nts_d         = nts_q;
    skip_d        = skip_q;
    layer_d       = layer_q;
    ts_d          = ts_q;
    exec_id_d     = exec_id_q;
    exec_start_d  = 1'b0;
    exec_cnt_d    = exec_cnt_q;
    busy_d        = busy_q;
    run_done_d    = 1'b0;
    run_aborted_d = 1'b0;
    err_d         = err_q;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      run_aborted_d = 1'b1;
      busy_d        = 1'b0;
      layer_d       = LAYER_ID_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          // abort outranks start even though it has no effect of its own here
          if (start && !abort) begin
            nl_d       = nl_clamped;
            nts_d      = num_timesteps;
            skip_d     = skip_mask;
            layer_d    = 8'd0;
            ts_d       = '0;
            exec_cnt_d = 32'd0;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = ((nl_clamped == 8'd0) || (num_timesteps == '0)) ? FINISH : CHECK;
          end
        end
        CHECK: begin
          state_d = skip_q[layer_q[LIDX_W-1:0]] ? NEXT : ISSUE;
        end
        ISSUE: begin
          if (exec.execute_done) begin
            exec_start_d = 1'b1;
            exec_id_d    = layer_q;
            exec_cnt_d   = exec_cnt_q + 32'd1;
            wd_clear     = 1'b1;
            state_d      = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          wd_enable = 1'b1;
          if (!exec.execute_done) state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          wd_enable = 1'b1;
          if (exec.execute_done) state_d = NEXT;
        end
        NEXT: begin
          if ((layer_q + 8'd1) < nl_q) begin
            layer_d = layer_q + 8'd1;
            state_d = CHECK;
          end else if (ts_q < (nts_q - TS_ONE)) begin
            layer_d = 8'd0;
            ts_d    = ts_q + TS_ONE;
            state_d = CHECK;
          end else begin
            state_d = FINISH;
          end
        end
        FINISH: begin
          run_done_d = 1'b1;
          busy_d     = 1'b0;
          layer_d    = LAYER_ID_NONE;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase

`ifdef SNN_SEQ_WATCHDOG_EN
      if (wd_expired && ((state_q == WAIT_ACK) || (state_q == WAIT_DONE))) begin
        state_d       = IDLE;
        run_aborted_d = 1'b1;
        busy_d        = 1'b0;
        err_d         = 1'b1;
        layer_d       = LAYER_ID_NONE;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      nl_q          <= 8'd0;
      nts_q         <= '0;
      skip_q        <= '0;
      layer_q       <= LAYER_ID_NONE;
      ts_q          <= '0;
      exec_id_q     <= LAYER_ID_NONE;
      exec_start_q  <= 1'b0;
      exec_cnt_q    <= 32'd0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      run_aborted_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      nl_q          <= nl_d;
      nts_q         <= nts_d;
      skip_q        <= skip_d;
      layer_q       <= layer_d;
      ts_q          <= ts_d;
      exec_id_q     <= exec_id_d;
      exec_start_q  <= exec_start_d;
      exec_cnt_q    <= exec_cnt_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      run_aborted_q <= run_aborted_d;
      err_q         <= err_d;
    end
  end

  assign exec.execute_layer_id = exec_id_q;
  assign exec.execute_start    = exec_start_q;
  assign busy                  = busy_q;
  assign run_done              = run_done_q;
  assign run_aborted           = run_aborted_q;
  assign current_layer         = layer_q;
  assign current_timestep      = ts_q;
  assign layers_executed       = exec_cnt_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Bench for snn_layer_sequencer: table-driven runs, randomized runs against an
// issue-order model, and hand-written abort / latency / reset / hang sequences.
module tb_snn_layer_sequencer;
  import snn_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_layers = 8'd0;
  logic [15:0] num_timesteps = 16'd0;
  logic [15:0] skip_mask = 16'd0;
  logic [19:0] wdog_limit = 20'd0;
  logic        busy, run_done, run_aborted, error_timeout;
  logic [7:0]  current_layer;
  logic [15:0] current_timestep;
  logic [31:0] layers_executed;

  snn_layer_sequencer_if exec_if ();

  snn_layer_sequencer #(.MAX_LAYERS(16), .TIMESTEP_WIDTH(16), .WDOG_WIDTH(20)) dut (
    .clk              (clk),
    .reset            (rst),
    .start            (start),
    .abort            (abort),
    .num_layers       (num_layers),
    .num_timesteps    (num_timesteps),
    .skip_mask        (skip_mask),
    .wdog_limit       (wdog_limit),
    .exec             (exec_if),
    .busy             (busy),
    .run_done         (run_done),
    .run_aborted      (run_aborted),
    .current_layer    (current_layer),
    .current_timestep (current_timestep),
    .layers_executed  (layers_executed),
    .error_timeout    (error_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Layer manager model: goes busy on execute_start, completes after mgr_lat cycles
  int mgr_lat = 4;
  bit mgr_hang = 1'b0;
  int mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_if.execute_done <= 1'b1;
      mcnt <= 0;
    end else if (exec_if.execute_start) begin
      exec_if.execute_done <= 1'b0;
      mcnt <= mgr_lat;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1 && !mgr_hang) begin
      mcnt <= 0;
      exec_if.execute_done <= 1'b1;
    end
  end

  int issued[$];
  int exp_ids[$];
  int cyc = 0;
  int done_cnt = 0, abort_cnt = 0, issue_cyc = 0, abort_cyc = 0;
  bit busy_prev = 1'b0, busy_ok = 1'b1;
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (exec_if.execute_start) begin
        issued.push_back(int'(exec_if.execute_layer_id));
        issue_cyc = cyc;
      end
      if (run_done) begin
        done_cnt++;
        if (busy || !busy_prev) busy_ok = 1'b0;
      end
      if (run_aborted) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
    end
    busy_prev = busy;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every unmasked layer of the clamped count, once per timestep, in order
  function automatic void build_model(input int nl, input int nts, input logic [15:0] mask);
    int eff;
    exp_ids.delete();
    eff = (nl > 16) ? 16 : nl;
    for (int t = 0; t < nts; t++)
      for (int l = 0; l < eff; l++)
        if (!mask[l]) exp_ids.push_back(l);
  endfunction

  task automatic clear_mon();
    issued.delete();
    done_cnt = 0;
    abort_cnt = 0;
    busy_ok = 1'b1;
  endtask

  task automatic run_case(input string name, input logic [7:0] nl, input logic [15:0] nts,
                          input logic [15:0] mask, input int lat, input int exp_cnt, input bit repulse);
    int ecnt;
    bit same;
    build_model(int'(nl), int'(nts), mask);
    ecnt = (exp_cnt < 0) ? exp_ids.size() : exp_cnt;
    clear_mon();
    mgr_lat = lat;
    @(negedge clk);
    num_layers = nl; num_timesteps = nts; skip_mask = mask; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_layers = 8'($urandom); num_timesteps = 16'($urandom); skip_mask = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (run_done || done_cnt > 0) break;
      @(negedge clk);
      start = repulse && (i % 7 == 3);
    end
    start = 1'b0;
    @(negedge clk);
    same = (issued.size() == exp_ids.size());
    if (same) foreach (exp_ids[k]) if (issued[k] != exp_ids[k]) same = 1'b0;
    chk({name, " run_done count"}, 64'(done_cnt), 64'd1);
    chk({name, " layers_executed"}, 64'(layers_executed), 64'(ecnt));
    chk({name, " issue count"}, 64'(issued.size()), 64'(ecnt));
    chk({name, " issue order"}, 64'(same), 64'd1);
    chk({name, " run_aborted count"}, 64'(abort_cnt), 64'd0);
    chk({name, " busy low"}, 64'(busy), 64'd0);
    chk({name, " busy falls with run_done"}, 64'(busy_ok), 64'd1);
    chk({name, " current_layer idle"}, 64'(current_layer), 64'hFF);
    chk({name, " error_timeout"}, 64'(error_timeout), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  nl;
    logic [15:0] nts;
    logic [15:0] mask;
    int          lat;
    int          exp_cnt;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int elapsed;
    tbl[0] = '{8'd3,  16'd2, 16'h0000, 4, 6};
    tbl[1] = '{8'd4,  16'd1, 16'h0005, 2, 2};
    tbl[2] = '{8'd0,  16'd5, 16'h0000, 3, 0};
    tbl[3] = '{8'd3,  16'd0, 16'h0000, 3, 0};
    tbl[4] = '{8'd20, 16'd1, 16'h0000, 1, 16};
    tbl[5] = '{8'd16, 16'd2, 16'hFFFF, 1, 0};
    tbl[6] = '{8'd5,  16'd3, 16'h0012, 2, 9};
    tbl[7] = '{8'd1,  16'd1, 16'h0000, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset run_done", 64'(run_done), 64'd0);
    chk("reset run_aborted", 64'(run_aborted), 64'd0);
    chk("reset execute_start", 64'(exec_if.execute_start), 64'd0);
    chk("reset execute_layer_id", 64'(exec_if.execute_layer_id), 64'hFF);
    chk("reset current_layer", 64'(current_layer), 64'hFF);
    chk("reset current_timestep", 64'(current_timestep), 64'd0);
    chk("reset layers_executed", 64'(layers_executed), 64'd0);
    chk("reset error_timeout", 64'(error_timeout), 64'd0);

    // First-issue latency: CHECK then ISSUE, pulse registered at the second edge
    clear_mon();
    mgr_lat = 3;
    @(negedge clk);
    num_layers = 8'd2; num_timesteps = 16'd1; skip_mask = 16'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat busy after accept", 64'(busy), 64'd1);
    chk("lat start edge0", 64'(exec_if.execute_start), 64'd0);
    chk("lat current_layer", 64'(current_layer), 64'd0);
    @(posedge clk); #1;
    chk("lat start edge1", 64'(exec_if.execute_start), 64'd0);
    @(posedge clk); #1;
    chk("lat start edge2", 64'(exec_if.execute_start), 64'd1);
    chk("lat layer id", 64'(exec_if.execute_layer_id), 64'd0);
    chk("lat layers_executed", 64'(layers_executed), 64'd1);
    @(posedge clk); #1;
    chk("lat start one cycle", 64'(exec_if.execute_start), 64'd0);
    for (int i = 0; i < 500 && done_cnt == 0; i++) @(negedge clk);
    chk("lat run completes", 64'(done_cnt), 64'd1);

    // Zero-count run: FINISH directly, run_done one edge later
    clear_mon();
    @(negedge clk);
    num_layers = 8'd0; num_timesteps = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero busy", 64'(busy), 64'd1);
    chk("zero run_done early", 64'(run_done), 64'd0);
    @(posedge clk); #1;
    chk("zero run_done", 64'(run_done), 64'd1);
    chk("zero busy falls", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero no issue", 64'(issued.size()), 64'd0);

    foreach (tbl[v])
      run_case($sformatf("tbl%0d", v), tbl[v].nl, tbl[v].nts, tbl[v].mask, tbl[v].lat, tbl[v].exp_cnt, 1'b0);

    run_case("restart ignored", 8'd20, 16'd2, 16'h0000, 2, 32, 1'b1);

    for (int r = 0; r < 12; r++)
      run_case($sformatf("rand%0d", r), 8'($urandom_range(0, 20)), 16'($urandom_range(0, 3)),
               16'($urandom), $urandom_range(1, 6), -1, (r % 3) == 0);

    // Abort while layer 1 is executing
    clear_mon();
    mgr_lat = 10;
    @(negedge clk);
    num_layers = 8'd3; num_timesteps = 16'd1; skip_mask = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && issued.size() < 2; i++) @(negedge clk);
    chk("abort reached layer1", 64'(issued.size()), 64'd2);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort run_aborted", 64'(run_aborted), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("abort pulse one cycle", 64'(run_aborted), 64'd0);
    repeat (20) @(negedge clk);
    chk("abort no run_done", 64'(done_cnt), 64'd0);
    chk("abort pulse count", 64'(abort_cnt), 64'd1);
    chk("abort no further issue", 64'(issued.size()), 64'd2);
    run_case("after abort", 8'd1, 16'd1, 16'h0000, 2, 1, 1'b0);

    // Manager that never completes
    clear_mon();
    mgr_lat = 3;
    mgr_hang = 1'b1;
    wdog_limit = 20'd100;
    @(negedge clk);
    num_layers = 8'd2; num_timesteps = 16'd1; skip_mask = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef SNN_SEQ_WATCHDOG_EN
    for (int i = 0; i < 400 && abort_cnt == 0; i++) @(negedge clk);
    elapsed = abort_cyc - issue_cyc;
    chk("wdog run_aborted", 64'(abort_cnt), 64'd1);
    chk("wdog elapsed near limit", 64'(elapsed >= 100 && elapsed <= 102), 64'd1);
    chk("wdog error_timeout", 64'(error_timeout), 64'd1);
    chk("wdog busy", 64'(busy), 64'd0);
    chk("wdog no run_done", 64'(done_cnt), 64'd0);
    mgr_hang = 1'b0;
    repeat (5) @(negedge clk);
    chk("wdog error sticky", 64'(error_timeout), 64'd1);
`else
    elapsed = 0;
    repeat (300) @(negedge clk);
    chk("hang no abort", 64'(abort_cnt + elapsed), 64'd0);
    chk("hang still busy", 64'(busy), 64'd1);
    chk("hang error_timeout", 64'(error_timeout), 64'd0);
    chk("hang single issue", 64'(issued.size()), 64'd1);
    chk("hang layers_executed", 64'(layers_executed), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    mgr_hang = 1'b0;
    repeat (5) @(negedge clk);
`endif
    run_case("after hang", 8'd2, 16'd1, 16'h0000, 2, 2, 1'b0);

    // Asynchronous reset in the middle of a run
    clear_mon();
    mgr_lat = 3;
    @(negedge clk);
    num_layers = 8'd4; num_timesteps = 16'd2; skip_mask = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst current_layer", 64'(current_layer), 64'hFF);
    chk("midrst execute_layer_id", 64'(exec_if.execute_layer_id), 64'hFF);
    chk("midrst layers_executed", 64'(layers_executed), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst no run_done", 64'(done_cnt), 64'd0);
    chk("midrst no run_aborted", 64'(abort_cnt), 64'd0);
    run_case("after reset", 8'd3, 16'd1, 16'h0002, 2, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_layer_sequencer.md
Name: snn_layer_sequencer

Overview:
- Controller that drives the SNN layer manager's execute_layer_id / execute_start / execute_done handshake.
- Walks layers 0..num_layers-1 in order for each of num_timesteps timesteps.
- Skips any layer masked out by software.
- Reports progress, completion, abort and (optionally) hung-layer timeout to the PS-side control registers.

Parameters:
- MAX_LAYERS, 16, number of layer slots in the layer manager; also the width of skip_mask.
- TIMESTEP_WIDTH, 16, width of num_timesteps and current_timestep.
- WDOG_WIDTH, 20, width of the watchdog counter (used only when the optional feature is compiled in).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a run; ignored while busy
- abort  in  1  stop the run immediately
- num_layers  in  8  layers per timestep; values above MAX_LAYERS are clamped to MAX_LAYERS
- num_timesteps  in  TIMESTEP_WIDTH  timesteps per run
- skip_mask  in  MAX_LAYERS  bit i=1 means layer i is not executed
- wdog_limit  in  WDOG_WIDTH  timeout in cycles for one layer (optional feature only)
- execute_layer_id  out  8  layer id sent to the layer manager
- execute_start  out  1  one-cycle pulse to the layer manager
- execute_done  in  1  level from the layer manager; 1 = idle/complete
- busy  out  1  high from the cycle after start is accepted until the run finishes or aborts
- run_done  out  1  one-cycle pulse on normal completion
- run_aborted  out  1  one-cycle pulse on abort or timeout
- current_layer  out  8  layer currently being processed
- current_timestep  out  TIMESTEP_WIDTH  timestep currently being processed
- layers_executed  out  32  count of execute_start pulses in this run
- error_timeout  out  1  sticky flag; cleared by the next accepted start

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE; all outputs 0.
  - execute_layer_id = 8'hFF; current_layer = 8'hFF.
- Parameters latched on start: num_layers (clamped), num_timesteps and skip_mask are captured when start is accepted in IDLE. Later changes have no effect on the current run.
- IDLE:
  - start=1: capture parameters; layer=0, timestep=0, layers_executed=0, error_timeout=0; busy=1.
  - If either captured count is 0, go to FINISH; otherwise go to CHECK.
- CHECK:
  - skip_mask[layer]=1: go to NEXT. A skipped layer costs 1 cycle and produces no execute_start.
  - Otherwise go to ISSUE.
- ISSUE:
  - Requires execute_done=1 (the manager is idle); otherwise stay in ISSUE.
  - Then drive execute_start=1 for exactly one cycle with execute_layer_id=layer, increment layers_executed, go to WAIT_ACK.
- WAIT_ACK: wait for execute_done=0 (the manager went active), then go to WAIT_DONE.
- WAIT_DONE: wait for execute_done=1, then go to NEXT.
- NEXT:
  - If layer < num_layers-1: layer+1, go to CHECK.
  - Else if timestep < num_timesteps-1: layer=0, timestep+1, go to CHECK.
  - Else go to FINISH.
- FINISH: run_done=1 for one cycle, busy=0, current_layer=8'hFF, go to IDLE.
- Latency: execute_start appears 2 cycles after the edge at which start is sampled (the CHECK cycle, then ISSUE), provided layer 0 is not skipped.
- Abort:
  - abort=1 in any non-IDLE state: next cycle is IDLE, run_aborted=1 for one cycle, busy=0, no run_done.
  - abort has priority over start and over every transition.
  - abort in IDLE has no effect.
- start while busy is ignored, and never generates a second execute_start.
- Counters:
  - layers_executed wraps modulo 2^32.
  - The timestep compare is unsigned at full TIMESTEP_WIDTH.
  - num_timesteps = all-ones runs 2^TIMESTEP_WIDTH-1 timesteps.
- Asynchronous reset mid-run returns immediately to the reset values. No run_done or run_aborted pulse is generated.

Optional Feature:
- Macro: SNN_SEQ_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to WAIT_ACK and increments each cycle spent in WAIT_ACK or WAIT_DONE.
  - When it reaches wdog_limit (and wdog_limit != 0): set error_timeout=1, pulse run_aborted, go to IDLE.
  - wdog_limit = 0 disables the timeout.
- Not defined:
  - No counter is built; the sequencer waits forever.
  - error_timeout is tied to 0; the wdog_limit port exists but is unused.

Decomposition:
- Shared package snn_seq_pkg holds the state encoding localparams (IDLE, CHECK, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH; 3 bits) and LAYER_ID_NONE = 8'hFF.
- One natural sub-module: snn_seq_watchdog (counter plus compare, with clear/enable/expired), instantiated only under SNN_SEQ_WATCHDOG_EN.

Test Plan:
- num_layers=3, num_timesteps=2, skip_mask=0, with a model manager that completes 4 cycles after execute_start -> ids 0,1,2,0,1,2 are issued; layers_executed=6; exactly one run_done; busy falls in the same cycle as run_done.
- num_layers=4, skip_mask=16'h0005, num_timesteps=1 -> only ids 1 and 3 are issued; layers_executed=2.
- num_layers=0 or num_timesteps=0 -> run_done 2 cycles after start; no execute_start.
- abort asserted in WAIT_DONE of layer 1 -> IDLE next cycle; run_aborted=1 for one cycle; no run_done; a new start then issues id 0.
- start pulsed again while busy; num_layers=20 -> no extra execute_start; num_layers is clamped so exactly 16 ids (0..15) are issued per timestep.
- SNN_SEQ_WATCHDOG_EN defined, wdog_limit=100, manager never completes -> after 100 cycles error_timeout=1 and run_aborted pulses. With the macro undefined, the same stimulus leaves the sequencer waiting in WAIT_DONE and error_timeout=0.
